rv32i_mem_arbiter: RTL and testbench

Shares one single-port instruction/data memory between the CPU's instruction-fetch port and its load/store port.
- Accepts one request at a time from either side.
- Drives it onto the memory port and routes the response back to the requester that owns it.
- Data requests have priority; a starvation counter guarantees fetch progress.
- Sits between the cpu core and the unified memory model used by the program testbenches.

---
 rtl/rv32i_mem_pkg.sv | 7 +
 rtl/rv32i_sat_counter.sv | 13 +
 rtl/rv32i_mem_arbiter.sv | 98 +++++++++
 tb/tb_rv32i_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared types and constants for the instruction/data memory arbiter
package rv32i_mem_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RESP} arb_state_t;
  typedef enum logic {OWNER_IF, OWNER_D} owner_t;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int WSTRB_WIDTH = MEM_DATA_WIDTH / 8;
endpackage

// File: rtl/rv32i_sat_counter.sv
// rv32i_sat_counter: saturating up-counter with synchronous clear
module rv32i_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    if (clear) count <= '0;
    else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one memory port between fetch and load/store with starvation guard
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_resp_valid,
  output logic [DATA_WIDTH-1:0]   if_resp_data,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic                    d_req_we,
  input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  output logic                    d_resp_valid,
  output logic [DATA_WIDTH-1:0]   d_resp_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_we,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic [31:0]             if_stall_cycles,
  output logic                    err_stray_resp
);
  arb_state_t            state;
  owner_t                owner;
  logic [3:0]            starve_cnt;
  logic [DATA_WIDTH-1:0] if_data_q, d_data_q;
  logic                  d_win, if_win, idle, resp;
  assign d_win         = d_req_valid && (!if_req_valid || starve_cnt != 4'(STARVE_LIMIT));
  assign if_win        = if_req_valid && !d_win;
  assign idle          = !reset && state == ARB_IDLE;
  assign resp          = !reset && state == ARB_WAIT_RESP && mem_resp_valid;
  assign if_req_ready  = idle && if_win;
  assign d_req_ready   = idle && d_win;
  assign if_resp_valid = resp && owner == OWNER_IF;
  assign d_resp_valid  = resp && owner == OWNER_D;
  assign if_resp_data  = if_resp_valid ? mem_resp_data : if_data_q;
  assign d_resp_data   = d_resp_valid ? mem_resp_data : d_data_q;
  rv32i_sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .inc   (if_req_valid && !if_req_ready),
    .clear (reset),
    .count (if_stall_cycles)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ARB_IDLE;
      owner          <= OWNER_IF;
      starve_cnt     <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_we     <= 1'b0;
      mem_req_wstrb  <= '0;
      mem_req_wdata  <= '0;
      if_data_q      <= '0;
      d_data_q       <= '0;
      err_stray_resp <= 1'b0;
    end else begin
      if (mem_resp_valid && state != ARB_WAIT_RESP) err_stray_resp <= 1'b1;
      case (state)
        ARB_IDLE:
          if (d_win || if_win) begin
            owner         <= d_win ? OWNER_D : OWNER_IF;
            mem_req_addr  <= d_win ? d_req_addr : if_req_addr;
            mem_req_we    <= d_win && d_req_we;
            mem_req_wstrb <= d_win ? d_req_wstrb : '0;
            mem_req_wdata <= d_win ? d_req_wdata : '0;
            starve_cnt    <= d_win ? starve_cnt + (if_req_valid ? 4'd1 : 4'd0) : 4'd0;
            mem_req_valid <= 1'b1;
            state         <= ARB_ISSUE;
          end
        ARB_ISSUE:
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ARB_WAIT_RESP;
          end
        ARB_WAIT_RESP:
          if (mem_resp_valid) begin
            if (owner == OWNER_IF) if_data_q <= mem_resp_data;
            else d_data_q <= mem_resp_data;
            state <= ARB_IDLE;
          end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: directed self-checking bench for the fetch/data memory arbiter
module tb_rv32i_mem_arbiter;
  logic        clk = 0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0] if_req_addr, if_resp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
  logic [3:0]  d_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] if_stall_cycles;
  logic        err_stray_resp;
  logic        sc_inc, sc_clear;
  logic [2:0]  sc_count;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  rv32i_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .if_stall_cycles(if_stall_cycles), .err_stray_resp(err_stray_resp)
  );
  rv32i_sat_counter #(.WIDTH(3)) u_sc (.clk(clk), .inc(sc_inc), .clear(sc_clear), .count(sc_count));
  task automatic test_reset;
    reset = 1; if_req_valid = 0; if_req_addr = 0; d_req_valid = 0; d_req_addr = 0;
    d_req_we = 0; d_req_wstrb = 0; d_req_wdata = 0; mem_req_ready = 1; mem_resp_valid = 0;
    mem_resp_data = 0; sc_inc = 0; sc_clear = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    checks++;
    if ({if_req_ready, d_req_ready, if_resp_valid, d_resp_valid, mem_req_valid, mem_req_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
        {if_req_ready, d_req_ready, if_resp_valid, d_resp_valid, mem_req_valid, mem_req_we});
    end
    checks++;
    if ({mem_req_addr, mem_req_wstrb, mem_req_wdata, if_resp_data, d_resp_data} !== '0) begin
      errors++; $display("FAIL reset_data got addr=%h wstrb=%h wdata=%h ifd=%h dd=%h want all 0",
        mem_req_addr, mem_req_wstrb, mem_req_wdata, if_resp_data, d_resp_data);
    end
    checks++;
    if (if_stall_cycles !== 0 || err_stray_resp !== 1'b0) begin
      errors++; $display("FAIL reset_stat got stall=%0d err=%b want 0 0", if_stall_cycles, err_stray_resp);
    end
  endtask
  task automatic test_fetch;
    @(negedge clk); if_req_valid = 1; if_req_addr = 32'h10; #1;
    checks++;
    if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
      errors++; $display("FAIL fetch_grant got if=%b d=%b want 1 0", if_req_ready, d_req_ready);
    end
    @(negedge clk); if_req_valid = 0; #1;
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb} !== {1'b1, 32'h10, 1'b0, 4'b0}) begin
      errors++; $display("FAIL fetch_issue got v=%b a=%h we=%b s=%h want 1 10 0 0",
        mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb);
    end
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = 32'h00b506b3; #1;
    checks++;
    if (if_resp_valid !== 1'b1 || if_resp_data !== 32'h00b506b3 || d_resp_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_resp got v=%b data=%h dv=%b want 1 00b506b3 0",
        if_resp_valid, if_resp_data, d_resp_valid);
    end
    @(negedge clk); mem_resp_valid = 0; mem_resp_data = 0; #1;
    checks++;
    if (if_resp_valid !== 1'b0 || if_resp_data !== 32'h00b506b3 || if_stall_cycles !== 0) begin
      errors++; $display("FAIL fetch_after got v=%b data=%h stall=%0d want 0 00b506b3 0",
        if_resp_valid, if_resp_data, if_stall_cycles);
    end
  endtask
  task automatic test_simultaneous;
    @(negedge clk);
    if_req_valid = 1; if_req_addr = 32'h20; d_req_valid = 1; d_req_addr = 32'h40; d_req_we = 0; #1;
    checks++;
    if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
      errors++; $display("FAIL simul_grant got d=%b if=%b want 1 0", d_req_ready, if_req_ready);
    end
    @(negedge clk); d_req_valid = 0; #1;
    checks++;
    if (mem_req_addr !== 32'h40 || if_stall_cycles !== 1) begin
      errors++; $display("FAIL simul_issue got addr=%h stall=%0d want 40 1", mem_req_addr, if_stall_cycles);
    end
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = 32'h1234_5678; #1;
    checks++;
    if (d_resp_valid !== 1'b1 || d_resp_data !== 32'h1234_5678 || if_resp_valid !== 1'b0) begin
      errors++; $display("FAIL simul_dresp got dv=%b data=%h iv=%b want 1 12345678 0",
        d_resp_valid, d_resp_data, if_resp_valid);
    end
    @(negedge clk); mem_resp_valid = 0; #1;
    checks++;
    if (if_req_ready !== 1'b1 || if_stall_cycles !== 3) begin
      errors++; $display("FAIL simul_fetch_cap got ready=%b stall=%0d want 1 3", if_req_ready, if_stall_cycles);
    end
    @(negedge clk); if_req_valid = 0; #1;
    checks++;
    if (mem_req_addr !== 32'h20 || mem_req_valid !== 1'b1) begin
      errors++; $display("FAIL simul_fetch_issue got addr=%h v=%b want 20 1", mem_req_addr, mem_req_valid);
    end
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = 32'hCAFE_0001; #1;
    checks++;
    if (if_resp_valid !== 1'b1 || if_resp_data !== 32'hCAFE_0001 || d_resp_valid !== 1'b0) begin
      errors++; $display("FAIL simul_iresp got iv=%b data=%h dv=%b want 1 cafe0001 0",
        if_resp_valid, if_resp_data, d_resp_valid);
    end
    @(negedge clk); mem_resp_valid = 0;
  endtask
  task automatic test_starvation;
    for (int g = 0; g < 6; g++) begin
      logic exp_d;
      exp_d = (g != 4);
      @(negedge clk);
      if_req_valid = 1; if_req_addr = 32'h30; d_req_valid = 1; d_req_addr = 32'h44; d_req_we = 0;
      mem_resp_valid = 0; #1;
      checks++;
      if (d_req_ready !== exp_d || if_req_ready !== !exp_d) begin
        errors++; $display("FAIL starve_grant%0d got d=%b if=%b want %b %b",
          g, d_req_ready, if_req_ready, exp_d, !exp_d);
      end
      @(negedge clk);
      @(negedge clk); mem_resp_valid = 1; mem_resp_data = 32'(g + 100); #1;
      checks++;
      if ((exp_d ? d_resp_valid : if_resp_valid) !== 1'b1) begin
        errors++; $display("FAIL starve_resp%0d got d=%b if=%b want owner=%s",
          g, d_resp_valid, if_resp_valid, exp_d ? "D" : "IF");
      end
    end
    @(negedge clk); if_req_valid = 0; d_req_valid = 0; mem_resp_valid = 0;
  endtask
  task automatic test_store;
    @(negedge clk);
    mem_req_ready = 0; d_req_valid = 1; d_req_we = 1; d_req_wstrb = 4'b0011;
    d_req_wdata = 32'hDEADBEEF; d_req_addr = 32'h80; #1;
    checks++;
    if (d_req_ready !== 1'b1) begin
      errors++; $display("FAIL store_grant got %b want 1", d_req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); d_req_valid = 0; d_req_we = 0; d_req_wstrb = 0; d_req_wdata = 0;
      if (i == 3) mem_req_ready = 1;
      #1;
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata} !==
          {1'b1, 32'h80, 1'b1, 4'b0011, 32'hDEADBEEF}) begin
        errors++; $display("FAIL store_hold%0d got v=%b a=%h we=%b s=%b d=%h want 1 80 1 0011 deadbeef",
          i, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata);
      end
    end
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = 32'h0000_0055; #1;
    checks++;
    if (mem_req_valid !== 1'b0 || d_resp_valid !== 1'b1 || d_resp_data !== 32'h55) begin
      errors++; $display("FAIL store_ack got mv=%b dv=%b data=%h want 0 1 55", mem_req_valid, d_resp_valid, d_resp_data);
    end
    @(negedge clk); mem_resp_valid = 0; #1;
    checks++;
    if (d_resp_valid !== 1'b0 || err_stray_resp !== 1'b0) begin
      errors++; $display("FAIL store_after got dv=%b err=%b want 0 0", d_resp_valid, err_stray_resp);
    end
  endtask
  task automatic test_reset_mid;
    @(negedge clk); if_req_valid = 1; if_req_addr = 32'h100;
    @(negedge clk); if_req_valid = 0;
    @(negedge clk); reset = 1; #1;
    checks++;
    if (if_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_in_reset got iv=%b dv=%b want 0 0", if_resp_valid, d_resp_valid);
    end
    @(negedge clk); reset = 0; mem_resp_valid = 1; mem_resp_data = 32'hBAD0_BAD0; #1;
    checks++;
    if ({if_resp_valid, d_resp_valid, mem_req_valid, err_stray_resp} !== 4'b0 ||
        if_resp_data !== 0 || d_resp_data !== 0 || mem_req_addr !== 0 || if_stall_cycles !== 0) begin
      errors++; $display("FAIL rmid_outputs got iv=%b dv=%b mv=%b err=%b ifd=%h dd=%h a=%h stall=%0d want all 0",
        if_resp_valid, d_resp_valid, mem_req_valid, err_stray_resp, if_resp_data, d_resp_data,
        mem_req_addr, if_stall_cycles);
    end
    @(negedge clk); mem_resp_valid = 0; #1;
    checks++;
    if (err_stray_resp !== 1'b1) begin
      errors++; $display("FAIL rmid_stray got %b want 1", err_stray_resp);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (err_stray_resp !== 1'b1) begin
      errors++; $display("FAIL rmid_sticky got %b want 1", err_stray_resp);
    end
  endtask
  task automatic test_saturation;
    @(negedge clk); sc_clear = 0; sc_inc = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      if (i == 6 || i == 10) begin
        checks++;
        if (sc_count !== 3'(i > 7 ? 7 : i)) begin
          errors++; $display("FAIL sat_count%0d got %0d want %0d", i, sc_count, i > 7 ? 7 : i);
        end
      end
    end
    sc_inc = 0; sc_clear = 1;
    @(negedge clk); #1;
    checks++;
    if (sc_count !== 3'd0) begin
      errors++; $display("FAIL sat_clear got %0d want 0", sc_count);
    end
    sc_clear = 0;
  endtask
  initial begin
    test_reset;
    test_fetch;
    test_simultaneous;
    test_starvation;
    test_store;
    test_reset_mid;
    test_saturation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
